// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam logic [3:0] FULL_BE = 4'b1111;

endpackage

// File: rtl/mem_arb_timer.sv
// Per-access wait counter: counts busy cycles without a memory ack and flags
// when the configured limit is reached. A limit of 0 never expires.
module mem_arb_timer
#(
    parameter int unsigned WAIT_LIMIT = 255
)
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    logic [CW-1:0] r_count;
    logic          w_at_limit;

    assign w_at_limit = (r_count == LIMIT);
    assign o_expired  = (WAIT_LIMIT != 0) && w_at_limit;

    // Saturates at the limit so a disabled timer (limit 0) stays parked at zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_limit) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges the core's instruction-fetch and data ports onto one single-ported
// memory bus with round-robin tie breaking, duplicate suppression and a wait timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned WAIT_LIMIT = 255
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              IReadEnable,
    input  logic [ADDR_W-1:0] IAddress,
    output logic [DATA_W-1:0] IReadData,
    output logic              IAck,
    input  logic              DReadEnable,
    input  logic              DWriteEnable,
    input  logic [ADDR_W-1:0] DAddress,
    input  logic [DATA_W-1:0] DWriteData,
    input  logic [3:0]        DByteEnable,
    output logic [DATA_W-1:0] DReadData,
    output logic              DAck,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic [3:0]        MemByteEnable,
    output logic              MemReadEnable,
    output logic              MemWriteEnable,
    input  logic              MemAck,
    input  logic [DATA_W-1:0] MemReadData,
    output logic              BusError
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    port_t             r_last_grant;
    logic              r_mask_i;
    logic              r_mask_d;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_be;
    logic              r_mem_re;
    logic              r_mem_we;
    logic              r_ack_i;
    logic              r_ack_d;
    logic [DATA_W-1:0] r_rdata_i;
    logic [DATA_W-1:0] r_rdata_d;
    logic              r_bus_error;

    logic w_req_i;
    logic w_req_d;
    logic w_grant_i;
    logic w_grant_d;
    logic w_busy;
    logic w_expired;
    logic w_done;
    logic w_timeout;
    logic w_timer_clear;
    logic w_timer_en;
    logic w_mem_re_next;
    logic w_mem_we_next;
    logic w_ack_i_next;
    logic w_ack_d_next;

    // A port is masked in its ack cycle and the one after, so a core that
    // still holds its enable is not served twice.
    assign w_req_i   = IReadEnable & ~r_mask_i;
    assign w_req_d   = (DReadEnable | DWriteEnable) & ~r_mask_d;
    assign w_grant_d = (r_state == IDLE) & w_req_d & (~w_req_i | (r_last_grant == PORT_I));
    assign w_grant_i = (r_state == IDLE) & w_req_i & ~w_grant_d;

    assign w_busy        = (r_state != IDLE);
    assign w_done        = w_busy & (MemAck | w_expired);
    assign w_timeout     = w_busy & w_expired & ~MemAck;
    assign w_timer_clear = ~w_busy;
    assign w_timer_en    = w_busy & ~MemAck;

    mem_arb_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_timer (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_clear   (w_timer_clear),
        .i_enable  (w_timer_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_next = D_BUSY;
                end else if (w_grant_i) begin
                    w_state_next = I_BUSY;
                end
            end
            I_BUSY, D_BUSY: begin
                if (w_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_mem_re_next = r_mem_re;
        w_mem_we_next = r_mem_we;
        w_ack_i_next  = 1'b0;
        w_ack_d_next  = 1'b0;
        case (r_state)
            IDLE: begin
                // Write wins over read when the data port raises both.
                w_mem_re_next = w_grant_i | (w_grant_d & ~DWriteEnable);
                w_mem_we_next = w_grant_d & DWriteEnable;
            end
            I_BUSY: begin
                if (w_done) begin
                    w_mem_re_next = 1'b0;
                    w_mem_we_next = 1'b0;
                    w_ack_i_next  = 1'b1;
                end
            end
            D_BUSY: begin
                if (w_done) begin
                    w_mem_re_next = 1'b0;
                    w_mem_we_next = 1'b0;
                    w_ack_d_next  = 1'b1;
                end
            end
            default: begin
                w_mem_re_next = 1'b0;
                w_mem_we_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_last_grant <= PORT_I;
            r_mask_i     <= 1'b0;
            r_mask_d     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_ack_i      <= 1'b0;
            r_ack_d      <= 1'b0;
            r_rdata_i    <= '0;
            r_rdata_d    <= '0;
            r_bus_error  <= 1'b0;
        end else begin
            r_mem_re <= w_mem_re_next;
            r_mem_we <= w_mem_we_next;
            r_ack_i  <= w_ack_i_next;
            r_ack_d  <= w_ack_d_next;
            r_mask_i <= w_ack_i_next | r_ack_i;
            r_mask_d <= w_ack_d_next | r_ack_d;

            if (w_grant_i) begin
                r_addr       <= IAddress;
                r_wdata      <= '0;
                r_be         <= FULL_BE;
                r_last_grant <= PORT_I;
            end else if (w_grant_d) begin
                r_addr       <= DAddress;
                r_wdata      <= DWriteData;
                r_be         <= DWriteEnable ? DByteEnable : FULL_BE;
                r_last_grant <= PORT_D;
            end

            // A timed-out access returns zero data to the waiting port.
            if (r_state == I_BUSY && w_done) begin
                r_rdata_i <= MemAck ? MemReadData : '0;
            end
            if (r_state == D_BUSY) begin
                if (w_timeout) begin
                    r_rdata_d <= '0;
                end else if (MemAck && !r_mem_we) begin
                    r_rdata_d <= MemReadData;
                end
            end

            if (w_timeout) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    assign IReadData      = r_rdata_i;
    assign IAck           = r_ack_i;
    assign DReadData      = r_rdata_d;
    assign DAck           = r_ack_d;
    assign MemAddress     = r_addr;
    assign MemWriteData   = r_wdata;
    assign MemByteEnable  = r_be;
    assign MemReadEnable  = r_mem_re;
    assign MemWriteEnable = r_mem_we;
    assign BusError       = r_bus_error;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-stamped access model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int WL = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          IReadEnable = 1'b0;
    logic [AW-1:0] IAddress = '0;
    logic [DW-1:0] IReadData;
    logic          IAck;
    logic          DReadEnable = 1'b0;
    logic          DWriteEnable = 1'b0;
    logic [AW-1:0] DAddress = '0;
    logic [DW-1:0] DWriteData = '0;
    logic [3:0]    DByteEnable = '0;
    logic [DW-1:0] DReadData;
    logic          DAck;
    logic [AW-1:0] MemAddress;
    logic [DW-1:0] MemWriteData;
    logic [3:0]    MemByteEnable;
    logic          MemReadEnable;
    logic          MemWriteEnable;
    logic          MemAck = 1'b0;
    logic [DW-1:0] MemReadData = '0;
    logic          BusError;

    initial forever #5 CLK = ~CLK;

    mem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .WAIT_LIMIT (WL)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .IReadEnable    (IReadEnable),
        .IAddress       (IAddress),
        .IReadData      (IReadData),
        .IAck           (IAck),
        .DReadEnable    (DReadEnable),
        .DWriteEnable   (DWriteEnable),
        .DAddress       (DAddress),
        .DWriteData     (DWriteData),
        .DByteEnable    (DByteEnable),
        .DReadData      (DReadData),
        .DAck           (DAck),
        .MemAddress     (MemAddress),
        .MemWriteData   (MemWriteData),
        .MemByteEnable  (MemByteEnable),
        .MemReadEnable  (MemReadEnable),
        .MemWriteEnable (MemWriteEnable),
        .MemAck         (MemAck),
        .MemReadData    (MemReadData),
        .BusError       (BusError)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- access-level model ----------------
    // Each access is tracked as (port, write?, cycles waited); a port's
    // request is ignored for two cycles starting at its recorded ack cycle.
    int          m_cyc = 0;
    bit          m_valid = 1'b0;
    bit          m_busy = 1'b0;
    int          m_port = 0;
    int          m_last = 0;
    int          m_waited = 0;
    bit          m_wr = 1'b0;
    int          m_ack_cyc [2];
    bit          m_tmo;
    bit          m_ri;
    bit          m_rd;
    int          m_win;
    logic        e_mre, e_mwe, e_iack, e_dack, e_berr;
    logic [31:0] e_maddr, e_mwdata, e_irdata, e_drdata;
    logic [3:0]  e_mbe;

    initial forever begin
        @(posedge CLK);
        if (!RST) begin
            m_valid = 1'b1;
            m_busy  = 1'b0;
            m_last  = 0;
            m_waited = 0;
            m_wr    = 1'b0;
            m_port  = 0;
            m_ack_cyc[0] = -100;
            m_ack_cyc[1] = -100;
            e_mre = 0; e_mwe = 0; e_iack = 0; e_dack = 0; e_berr = 0;
            e_maddr = 0; e_mwdata = 0; e_irdata = 0; e_drdata = 0; e_mbe = 0;
        end else begin
            e_iack = 0;
            e_dack = 0;
            if (m_busy) begin
                m_tmo = !MemAck && (WL != 0) && (m_waited == WL);
                if (MemAck || m_tmo) begin
                    m_busy = 1'b0;
                    e_mre  = 0;
                    e_mwe  = 0;
                    m_ack_cyc[m_port] = m_cyc + 1;
                    if (m_port == 0) begin
                        e_iack   = 1;
                        e_irdata = m_tmo ? 32'h0 : MemReadData;
                    end else begin
                        e_dack = 1;
                        if (m_tmo) e_drdata = 32'h0;
                        else if (!m_wr) e_drdata = MemReadData;
                    end
                    if (m_tmo) e_berr = 1;
                end else begin
                    m_waited++;
                end
            end else begin
                m_ri = IReadEnable && !((m_cyc - m_ack_cyc[0]) <= 1);
                m_rd = (DReadEnable || DWriteEnable) && !((m_cyc - m_ack_cyc[1]) <= 1);
                if (m_ri || m_rd) begin
                    m_win    = (m_ri && m_rd) ? (1 - m_last) : (m_rd ? 1 : 0);
                    m_busy   = 1'b1;
                    m_port   = m_win;
                    m_last   = m_win;
                    m_waited = 0;
                    if (m_win == 0) begin
                        m_wr = 1'b0;
                        e_maddr = IAddress; e_mwdata = 32'h0; e_mbe = 4'hF;
                        e_mre = 1; e_mwe = 0;
                    end else begin
                        m_wr = DWriteEnable;
                        e_maddr  = DAddress;
                        e_mwdata = DWriteData;
                        e_mbe    = DWriteEnable ? DByteEnable : 4'hF;
                        e_mre    = !DWriteEnable;
                        e_mwe    = DWriteEnable;
                    end
                end
            end
        end
        m_cyc++;
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge CLK);
        if (m_valid) begin
            chk("MemReadEnable",  64'(MemReadEnable),  64'(e_mre));
            chk("MemWriteEnable", 64'(MemWriteEnable), 64'(e_mwe));
            chk("IAck",           64'(IAck),           64'(e_iack));
            chk("DAck",           64'(DAck),           64'(e_dack));
            chk("BusError",       64'(BusError),       64'(e_berr));
            chk("IReadData",      64'(IReadData),      64'(e_irdata));
            chk("DReadData",      64'(DReadData),      64'(e_drdata));
            chk("MemAddress",     64'(MemAddress),     64'(e_maddr));
            chk("MemWriteData",   64'(MemWriteData),   64'(e_mwdata));
            chk("MemByteEnable",  64'(MemByteEnable),  64'(e_mbe));
            if (IAck) $display("txn t=%0t port=I rdata=%h berr=%0b", $time, IReadData, BusError);
            if (DAck) $display("txn t=%0t port=D rdata=%h berr=%0b", $time, DReadData, BusError);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
    endtask

    logic [31:0] order_exp [4];
    int          budget;

    initial begin
        // reset values
        RST = 1'b0;
        tick();
        tick();
        chk("rst_IAck",      64'(IAck),           64'(0));
        chk("rst_MemRE",     64'(MemReadEnable),  64'(0));
        chk("rst_MemWE",     64'(MemWriteEnable), 64'(0));
        chk("rst_BusError",  64'(BusError),       64'(0));
        chk("rst_IReadData", 64'(IReadData),      64'(0));
        chk("rst_MemAddr",   64'(MemAddress),     64'(0));
        RST = 1'b1;

        // 1: I-only read, MemAck at cycle 3
        IReadEnable = 1; IAddress = 32'h40;
        tick();                                            // c1
        chk("t1_re_c1",   64'(MemReadEnable), 64'(1));
        chk("t1_addr",    64'(MemAddress),    64'(32'h40));
        tick();                                            // c2
        tick();                                            // c3
        chk("t1_re_c3",   64'(MemReadEnable), 64'(1));
        MemAck = 1; MemReadData = 32'h2402_0005;
        tick();                                            // c4
        MemAck = 0; MemReadData = 32'hFFFF_FFFF;
        chk("t1_iack_c4", 64'(IAck),          64'(1));
        chk("t1_idata",   64'(IReadData),     64'(32'h2402_0005));
        chk("t1_re_c4",   64'(MemReadEnable), 64'(0));
        tick();                                            // c5, enable still held
        chk("t1_iack_c5", 64'(IAck),          64'(0));
        tick();                                            // c6
        chk("t1_noreissue", 64'(MemReadEnable), 64'(0));
        IReadEnable = 0;
        tick();
        tick();

        // 2: tie right after reset, D write served first
        do_reset();
        IReadEnable = 1; IAddress = 32'h80;
        DWriteEnable = 1; DAddress = 32'h100; DWriteData = 32'hDEAD_BEEF; DByteEnable = 4'b0011;
        tick();                                            // c1
        chk("t2_we",    64'(MemWriteEnable), 64'(1));
        chk("t2_re",    64'(MemReadEnable),  64'(0));
        chk("t2_addr",  64'(MemAddress),     64'(32'h100));
        chk("t2_wdata", 64'(MemWriteData),   64'(32'hDEAD_BEEF));
        chk("t2_be",    64'(MemByteEnable),  64'(4'b0011));
        MemAck = 1;
        tick();                                            // c2
        MemAck = 0; DWriteEnable = 0;
        chk("t2_dack",  64'(DAck),           64'(1));
        tick();                                            // c3
        chk("t2_i_re",   64'(MemReadEnable), 64'(1));
        chk("t2_i_addr", 64'(MemAddress),    64'(32'h80));
        MemAck = 1; MemReadData = 32'h1111_2222;
        tick();                                            // c4
        MemAck = 0; IReadEnable = 0;
        chk("t2_iack",  64'(IAck),           64'(1));
        chk("t2_ddata", 64'(DReadData),      64'(0));
        tick();
        tick();

        // 3: both held for four accesses -> D, I, D, I
        order_exp[0] = 32'h300; order_exp[1] = 32'h200;
        order_exp[2] = 32'h300; order_exp[3] = 32'h200;
        IReadEnable = 1; IAddress = 32'h200;
        DReadEnable = 1; DAddress = 32'h300;
        for (int n = 0; n < 4; n++) begin
            budget = 0;
            while (!(MemReadEnable || MemWriteEnable) && budget < 20) begin
                tick();
                budget++;
            end
            chk("t3_grant_in_time", 64'(budget < 20),  64'(1));
            chk("t3_order",         64'(MemAddress),   64'(order_exp[n]));
            MemAck = 1; MemReadData = 32'hA000_0000 + 32'(n);
            if (n == 3) begin
                IReadEnable = 0;
                DReadEnable = 0;
            end
            tick();
            MemAck = 0;
        end
        chk("t3_last_iack", 64'(IAck),      64'(1));
        chk("t3_ddata",     64'(DReadData), 64'(32'hA000_0002));
        chk("t3_idata",     64'(IReadData), 64'(32'hA000_0003));
        tick();
        tick();
        tick();

        // 4: D read never acked -> timeout after WL waits, then a normal access
        DReadEnable = 1; DAddress = 32'h500;
        budget = 0;
        while (!DAck && budget < 20) begin
            tick();
            budget++;
        end
        chk("t4_dack_cycle", 64'(budget),    64'(6));
        chk("t4_ddata_zero", 64'(DReadData), 64'(0));
        chk("t4_buserror",   64'(BusError),  64'(1));
        DReadEnable = 0;
        tick();
        tick();
        tick();
        IReadEnable = 1; IAddress = 32'h44;
        tick();                                            // c1
        MemAck = 1; MemReadData = 32'h5555_AAAA;
        tick();                                            // c2
        MemAck = 0; IReadEnable = 0;
        chk("t4_next_iack",  64'(IAck),      64'(1));
        chk("t4_next_idata", 64'(IReadData), 64'(32'h5555_AAAA));
        chk("t4_sticky",     64'(BusError),  64'(1));
        tick();
        tick();

        // 5: reset during D_BUSY, stray MemAck afterwards
        DReadEnable = 1; DAddress = 32'h700;
        tick();                                            // c1
        tick();                                            // c2
        RST = 0; DReadEnable = 0;
        tick();                                            // c3
        chk("t5_re_dropped", 64'(MemReadEnable), 64'(0));
        chk("t5_berr_clear", 64'(BusError),      64'(0));
        RST = 1; MemAck = 1; MemReadData = 32'h1234_5678;
        tick();                                            // c4
        chk("t5_no_dack",    64'(DAck),          64'(0));
        chk("t5_no_capture", 64'(DReadData),     64'(0));
        MemAck = 0;
        tick();
        chk("t5_no_dack2",   64'(DAck),          64'(0));

        // 6: read and write together -> write only
        DReadEnable = 1; DWriteEnable = 1;
        DAddress = 32'h600; DWriteData = 32'h0BAD_F00D; DByteEnable = 4'b1100;
        tick();                                            // c1
        chk("t6_we",    64'(MemWriteEnable), 64'(1));
        chk("t6_re",    64'(MemReadEnable),  64'(0));
        chk("t6_be",    64'(MemByteEnable),  64'(4'b1100));
        chk("t6_wdata", 64'(MemWriteData),   64'(32'h0BAD_F00D));
        MemAck = 1; MemReadData = 32'h7777_7777;
        tick();                                            // c2
        MemAck = 0; DReadEnable = 0; DWriteEnable = 0;
        chk("t6_dack",  64'(DAck),           64'(1));
        chk("t6_ddata", 64'(DReadData),      64'(0));
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Downstream of the processor core: merges the core's instruction-fetch port and data-memory port onto one single-ported external memory bus.
- Each core port uses a level request, held until a one-cycle Ack. The memory bus uses the same enable/ack convention.
- Arbitration is round-robin on ties; the winner's request is latched for the whole access.
- A per-access wait timer aborts hung accesses and raises a sticky BusError.

Parameters:
- ADDR_W, 32, address width for both ports and the memory bus
- DATA_W, 32, data width
- WAIT_LIMIT, 255, maximum cycles in a BUSY state before abort; 0 disables the timer

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-low
- IReadEnable  in  1  instruction read request (level, held until IAck)
- IAddress  in  ADDR_W  instruction address (PC)
- IReadData  out  DATA_W  fetched instruction
- IAck  out  1  one-cycle completion pulse, instruction port
- DReadEnable  in  1  data read request
- DWriteEnable  in  1  data write request
- DAddress  in  ADDR_W  data address
- DWriteData  in  DATA_W  store data
- DByteEnable  in  4  byte lanes for the store
- DReadData  out  DATA_W  load data
- DAck  out  1  one-cycle completion pulse, data port
- MemAddress  out  ADDR_W  bus address
- MemWriteData  out  DATA_W  bus write data
- MemByteEnable  out  4  bus byte lanes
- MemReadEnable  out  1  bus read strobe (level)
- MemWriteEnable  out  1  bus write strobe (level)
- MemAck  in  1  bus completion
- MemReadData  in  DATA_W  bus read data, valid with MemAck
- BusError  out  1  sticky: a timeout has occurred

Behaviour:
- Reset (RST==0 at a rising edge):
  - state=IDLE, lastGrant=I, all masks cleared, timer=0.
  - All enables, acks and BusError are 0; IReadData and DReadData are 0; Mem address/data/byte-enable are 0.
  - An in-flight access is abandoned.
- States: IDLE, I_BUSY, D_BUSY.
- Effective requests in IDLE:
  - reqI = IReadEnable & ~maskI.
  - reqD = (DReadEnable | DWriteEnable) & ~maskD.
- IDLE arbitration:
  - Only one request active: that port wins.
  - Both active: the port not equal to lastGrant wins. After reset, D wins the first tie.
  - At the edge, latch the winner's address, write data and byte enable; go to I_BUSY or D_BUSY; set lastGrant; clear the timer.
- BUSY states:
  - MemReadEnable / MemWriteEnable are driven from the latched request. The enables are registered, so they first assert in the cycle after the grant.
  - I port: read only; MemByteEnable=4'b1111.
  - D port: DWriteEnable has precedence over DReadEnable. A write drives MemWriteEnable=1, MemReadEnable=0. A read drives MemByteEnable=4'b1111.
  - Latched fields stay stable even if core inputs change.
- Completion (MemAck==1 in a BUSY state):
  - Next cycle: the granted port's Ack=1 for exactly one cycle, state=IDLE, Mem enables=0.
  - Reads: MemReadData is captured into IReadData or DReadData at the MemAck edge.
  - Writes: DReadData is unchanged.
  - Both ReadData outputs hold their value until the next read completion on that port.
- Latency:
  - Request seen in IDLE at cycle 0; Mem enable high at cycle 1.
  - With MemAck at cycle k, Ack is at k+1.
  - Zero-wait memory (MemAck at cycle 1) gives a 2-cycle round trip.
- Duplicate suppression:
  - maskX is set in the cycle port X's Ack is high and in the following cycle, then clears.
  - This covers the core holding its enable for up to 2 cycles after ack.
  - The other port may be granted during this window.
- Stray MemAck while in IDLE is ignored: no port Ack and no data capture.
- Timeout (WAIT_LIMIT>0):
  - The timer increments each BUSY cycle without MemAck.
  - When timer==WAIT_LIMIT and MemAck==0: Ack the port next cycle with ReadData=0, set BusError, return to IDLE.
  - MemAck in the same cycle the limit is reached counts as normal completion.
  - BusError clears only on reset.
- Reset mid-access: enables drop the cycle after the reset edge; no Ack is issued for the abandoned access.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum arb_state_t {IDLE, I_BUSY, D_BUSY}
  - typedef enum port_t {PORT_I, PORT_D}
  - constant FULL_BE = 4'b1111
- One natural sub-module, mem_arb_timer: counter with clear, enable, limit compare and expired output, parameterised by WAIT_LIMIT.

Test Plan:
- I-only read, IAddress=0x40, MemAck at cycle 3 with 0x2402_0005 -> MemReadEnable cycles 1-3, IAck at cycle 4, IReadData=0x2402_0005, no re-issue while IReadEnable is held 2 cycles after IAck.
- IReadEnable and DWriteEnable both high at cycle 0 after reset, DAddress=0x100, DWriteData=0xDEAD_BEEF, DByteEnable=4'b0011 -> D served first (MemWriteEnable, BE=0011), then I; DReadData stays 0.
- Both ports held continuously for 4 accesses -> grant order D, I, D, I.
- D read with no MemAck, WAIT_LIMIT=4 -> DAck after the limit with DReadData=0, BusError=1 and sticky; the next access completes normally.
- RST low during D_BUSY, then MemAck arrives in IDLE -> no DAck, no data capture, all outputs at reset values.
- DReadEnable and DWriteEnable both high -> write performed, MemReadEnable stays 0.
